// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one 32-bit word per line.
// Load hits return data in the same cycle; misses and all stores stall until mem_ready.
module data_cache #(
    parameter int SETS  = 256,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    input  logic [1:0]  DataWidth,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_ren,
    output logic        mem_wen,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  dbg_state
);

    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {IDLE, READ_MISS, WRITE_THRU} state_t;

    state_t            state;
    logic [31:0]       data_q [SETS];
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [SETS-1:0]   valid_q;
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    logic [31:0]       load_src;
    logic [15:0]       half_sel;
    logic [7:0]        byte_sel;
    logic [31:0]       load_data;
    logic [3:0]        st_be;
    logic [31:0]       st_data;

    assign idx       = cpu_addr[IDX_W+1:2];
    assign tag       = cpu_addr[31:IDX_W+2];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign mem_addr  = {cpu_addr[31:2], 2'b00};
    assign dbg_state = state;

    // Load lane extraction; during a miss the returning memory word is the source.
    always_comb begin
        load_src = (state == READ_MISS) ? mem_rdata : data_q[idx];
        half_sel = cpu_addr[1] ? load_src[31:16] : load_src[15:0];
        case (cpu_addr[1:0])
            2'd0:    byte_sel = load_src[7:0];
            2'd1:    byte_sel = load_src[15:8];
            2'd2:    byte_sel = load_src[23:16];
            default: byte_sel = load_src[31:24];
        endcase
        case (DataWidth)
            2'b01:   load_data = {16'h0, half_sel};
            2'b10:   load_data = {24'h0, byte_sel};
            default: load_data = load_src;
        endcase
    end

    always_comb begin
        st_be   = 4'b1111;
        st_data = cpu_wdata;
        case (DataWidth)
            2'b01: begin
                st_be   = cpu_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {16'h0, cpu_wdata[15:0]} << {cpu_addr[1], 4'b0000};
            end
            2'b10: begin
                st_be   = 4'b0001 << cpu_addr[1:0];
                st_data = {24'h0, cpu_wdata[7:0]} << {cpu_addr[1:0], 3'b000};
            end
            default: ;
        endcase
    end

    // Handshake: the CPU holds its request stable while stall is high; the backing
    // memory completes the single outstanding mem_ren/mem_wen request in the cycle
    // mem_ready is high, and stall drops in that same cycle.
    always_comb begin
        stall     = 1'b0;
        cpu_rdata = 32'h0;
        case (state)
            IDLE: begin
                if (cpu_wen) begin
                    stall = 1'b1;
                end else if (cpu_ren) begin
                    if (hit) cpu_rdata = load_data;
                    else     stall     = 1'b1;
                end
            end
            READ_MISS: begin
                stall = !mem_ready;
                if (mem_ready) cpu_rdata = load_data;
            end
            WRITE_THRU: stall = !mem_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid_q    <= '0;
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
            mem_ren    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_wen) begin
                        state     <= WRITE_THRU;
                        mem_wen   <= 1'b1;
                        mem_be    <= st_be;
                        mem_wdata <= st_data;
                    end else if (cpu_ren) begin
                        if (hit) begin
                            if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
                        end else begin
                            state   <= READ_MISS;
                            mem_ren <= 1'b1;
                        end
                    end
                end
                READ_MISS: begin
                    if (mem_ready) begin
                        data_q[idx]  <= mem_rdata;
                        tag_q[idx]   <= tag;
                        valid_q[idx] <= 1'b1;
                        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
                        mem_ren      <= 1'b0;
                        state        <= IDLE;
                    end
                end
                WRITE_THRU: begin
                    if (mem_ready) begin
                        // No write-allocate: only a resident line picks up the store.
                        if (hit) begin
                            for (int b = 0; b < 4; b++) begin
                                if (mem_be[b]) data_q[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                            end
                        end
                        mem_wen   <= 1'b0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= 32'h0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: loads/stores with a bench-driven backing memory
// and hand-computed expected values.
module tb_data_cache;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ren;
    logic        cpu_wen;
    logic [1:0]  DataWidth;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int both_cnt = 0;
    logic [31:0] exp_q[$];

    data_cache dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ren   (cpu_ren),
        .cpu_wen   (cpu_wen),
        .DataWidth (DataWidth),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (mem_ren && mem_wen) both_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    endtask

    // driver: load, with memory answering after `delay` cycles of mem_ren
    task automatic do_load(input logic [31:0] addr, input logic [1:0] dw, input logic [31:0] word,
                           input int delay, output logic [31:0] data, output int stall_n,
                           output int ren_n);
        logic done;
        done = 1'b0; stall_n = 0; ren_n = 0; data = 32'h0;
        cpu_addr = addr; DataWidth = dw; cpu_ren = 1'b1; cpu_wen = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_ren) begin
                ren_n++;
                if (ren_n > delay) begin mem_ready = 1'b1; mem_rdata = word; end
            end
            #1;
            if (stall) stall_n++;
            else begin data = cpu_rdata; done = 1'b1; end
            @(posedge clk); #1;
            mem_ready = 1'b0;
        end
        cpu_ren = 1'b0;
        check("load_done", {31'h0, done}, 32'h1);
    endtask

    // driver: store, capturing the lane presented to memory
    task automatic do_store(input logic [31:0] addr, input logic [1:0] dw, input logic [31:0] wd,
                            input int delay, output logic [3:0] be, output logic [31:0] bus,
                            output int wen_n);
        logic done;
        done = 1'b0; wen_n = 0; be = 4'h0; bus = 32'h0;
        cpu_addr = addr; DataWidth = dw; cpu_wdata = wd; cpu_wen = 1'b1; cpu_ren = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_wen) begin
                wen_n++; be = mem_be; bus = mem_wdata;
                if (wen_n > delay) mem_ready = 1'b1;
            end
            #1;
            if (!stall) done = 1'b1;
            @(posedge clk); #1;
            mem_ready = 1'b0;
        end
        cpu_wen = 1'b0;
        check("store_done", {31'h0, done}, 32'h1);
    endtask

    // scoreboard: expected load data queued, then compared on completion
    task automatic load_check(input string tag, input logic [31:0] addr, input logic [1:0] dw,
                              input logic [31:0] word, input int delay, input logic [31:0] exp,
                              input int exp_ren);
        logic [31:0] data;
        int st_n, ren_n;
        exp_q.push_back(exp);
        do_load(addr, dw, word, delay, data, st_n, ren_n);
        check({tag, "_data"}, data, exp_q.pop_front());
        check({tag, "_ren"}, ren_n, exp_ren);
    endtask

    initial begin
        logic [31:0] data, bus;
        logic [3:0]  be;
        int st_n, ren_n, wen_n;

        rst = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_ren = 1'b0; cpu_wen = 1'b0;
        DataWidth = 2'b00; mem_rdata = 32'h0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cpu_addr = 32'h0001_0000;
        @(negedge clk);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_mem_ren", {31'h0, mem_ren}, 32'h0);
        check("rst_mem_wen", {31'h0, mem_wen}, 32'h0);
        check("rst_mem_be", {28'h0, mem_be}, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_state", {30'h0, dbg_state}, 32'h0);
        check("rst_miss_cnt", dut.miss_count, 32'h0);
        @(posedge clk); #1;

        // cold miss, memory answers after 3 cycles of mem_ren
        do_load(32'h0001_0000, 2'b00, 32'hDEAD_BEEF, 3, data, st_n, ren_n);
        check("miss_data", data, 32'hDEAD_BEEF);
        check("miss_stall_cycles", st_n, 4);
        check("miss_ren_cycles", ren_n, 4);
        check("miss_count_1", dut.miss_count, 32'h1);

        do_load(32'h0001_0000, 2'b00, 32'h0, 0, data, st_n, ren_n);
        check("hit_data", data, 32'hDEAD_BEEF);
        check("hit_stall", st_n, 0);
        check("hit_ren", ren_n, 0);
        check("hit_count_1", dut.hit_count, 32'h1);

        do_store(32'h0001_0002, 2'b10, 32'h0000_005A, 0, be, bus, wen_n);
        check("sb_be", {28'h0, be}, 32'h4);
        check("sb_lane", {24'h0, bus[23:16]}, 32'h5A);
        check("sb_wen_cycles", wen_n, 1);
        load_check("lw_after_sb", 32'h0001_0000, 2'b00, 32'h0, 0, 32'hDE5A_BEEF, 0);

        load_check("lh_hi", 32'h0001_0002, 2'b01, 32'h0, 0, 32'h0000_DE5A, 0);
        load_check("lb_3", 32'h0001_0003, 2'b10, 32'h0, 0, 32'h0000_00DE, 0);
        load_check("lb_0", 32'h0001_0000, 2'b10, 32'h0, 0, 32'h0000_00EF, 0);
        load_check("lb_1", 32'h0001_0001, 2'b10, 32'h0, 0, 32'h0000_00BE, 0);
        load_check("lh_lo_odd", 32'h0001_0001, 2'b01, 32'h0, 0, 32'h0000_BEEF, 0);
        load_check("lw_w11", 32'h0001_0003, 2'b11, 32'h0, 0, 32'hDE5A_BEEF, 0);

        do_store(32'h0001_0002, 2'b01, 32'hFFFF_1234, 1, be, bus, wen_n);
        check("sh_be", {28'h0, be}, 32'hC);
        check("sh_bus", bus, 32'h1234_0000);
        load_check("lw_after_sh", 32'h0001_0000, 2'b00, 32'h0, 0, 32'h1234_BEEF, 0);

        // store miss to a conflicting index: write-through only, no allocation
        do_store(32'h0002_0000, 2'b00, 32'hCAFE_F00D, 2, be, bus, wen_n);
        check("sw_miss_be", {28'h0, be}, 32'hF);
        check("sw_miss_bus", bus, 32'hCAFE_F00D);
        check("sw_miss_wen_cycles", wen_n, 3);
        load_check("resident_kept", 32'h0001_0000, 2'b00, 32'h0, 0, 32'h1234_BEEF, 0);
        load_check("no_alloc", 32'h0002_0000, 2'b00, 32'h1111_2222, 0, 32'h1111_2222, 1);
        check("miss_count_2", dut.miss_count, 32'h2);
        load_check("conflict_evict", 32'h0001_0000, 2'b00, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1);

        // reset in the middle of a read miss
        cpu_addr = 32'h0004_0004; DataWidth = 2'b00; cpu_ren = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rm_state", {30'h0, dbg_state}, 32'h1);
        check("rm_mem_ren", {31'h0, mem_ren}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cpu_ren = 1'b0;
        @(negedge clk);
        check("abort_state", {30'h0, dbg_state}, 32'h0);
        check("abort_mem_ren", {31'h0, mem_ren}, 32'h0);
        check("abort_stall", {31'h0, stall}, 32'h0);
        check("abort_miss_cnt", dut.miss_count, 32'h0);
        @(posedge clk); #1;
        load_check("after_rst_miss", 32'h0001_0000, 2'b00, 32'h7777_8888, 0, 32'h7777_8888, 1);

        check("ren_wen_exclusive", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", n_checks, n_checks + 1);
        $fatal(1, "timeout");
    end

endmodule
